int_ctrl: RTL and testbench

- Interrupt controller between the peripheral interrupt lines (timers, UART, switches) and the CP0 HWInt[7:2] input.
- Latches each source as level- or edge-triggered and applies per-source enables.
- Picks one winner by fixed priority and presents it to CP0 as a one-hot HWInt.
- Tracks the interrupt through claim/service/complete; software reaches it over the system bridge as a 16-byte register window.

---
 rtl/int_ctrl_pkg.sv | 9 +
 rtl/int_prio_enc.sv | 15 +
 rtl/int_ctrl.sv | 76 +++++++
 tb/tb_int_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register offsets, FSM states and bridge window base shared by the interrupt controller.
package int_ctrl_pkg;
    localparam logic [1:0] INT_PEND = 2'd0;
    localparam logic [1:0] INT_EN   = 2'd1;
    localparam logic [1:0] INT_EDGE = 2'd2;
    localparam logic [1:0] INT_ACT  = 2'd3;
    localparam logic [31:0] INT_BASE = 32'h0000_7f20;
    typedef enum logic [1:0] {INT_IDLE, INT_ASSERT, INT_ACTIVE} int_state_t;
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-wins priority encoder producing {valid, id}.
module int_prio_enc #(
    parameter int N_SRC = 6
) (
    input  logic [N_SRC-1:0] req,
    output logic             valid,
    output logic [2:0]       id
);
    always_comb begin
        id = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (req[i]) id = 3'(i);
        valid = |req;
    end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: level/edge interrupt latch, fixed-priority pick and claim/complete FSM feeding CP0 HWInt.
// Define INT_CTRL_SYNC_EN to pass irq_src through a 2-flop synchronizer first.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             we,
    input  logic [3:0]       addr,
    input  logic [31:0]      wd,
    output logic [31:0]      rd,
    input  logic             cp0_req,
    output logic [5:0]       HWInt,
    output logic             busy
);
    int_state_t       state, state_d;
    logic [N_SRC-1:0] src, prev, pend_q, pend, en, edge_q, clr, win_oh;
    logic [2:0]       win_id, act_id, enc_id;
    logic             enc_valid, claim;
    logic             unused;
    assign unused = ^{addr[1:0], wd[31:N_SRC]};
`ifdef INT_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1, sync2;
    always_ff @(posedge clk) begin
        sync1 <= reset ? '0 : irq_src;
        sync2 <= reset ? '0 : sync1;
    end
    assign src = sync2;
`else
    assign src = irq_src;
`endif
    // Level sources follow the line directly; only edge sources hold state.
    assign pend   = (edge_q & pend_q) | (~edge_q & src);
    assign win_oh = N_SRC'(1) << win_id;
    assign claim  = state == INT_ASSERT && cp0_req;
    assign clr    = (we && addr[3:2] == INT_PEND ? wd[N_SRC-1:0] : '0) | (claim ? win_oh : '0);
    int_prio_enc #(.N_SRC(N_SRC)) u_enc (.req(pend & en), .valid(enc_valid), .id(enc_id));
    always_comb begin
        state_d = state;
        case (state)
            INT_IDLE:   state_d = enc_valid ? INT_ASSERT : INT_IDLE;
            INT_ASSERT: state_d = cp0_req ? INT_ACTIVE : (|(pend & en & win_oh)) ? INT_ASSERT : INT_IDLE;
            INT_ACTIVE: state_d = we && addr[3:2] == INT_ACT ? INT_IDLE : INT_ACTIVE;
            default:    state_d = INT_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= INT_IDLE;
            prev   <= '0;
            pend_q <= '0;
            en     <= '0;
            edge_q <= '0;
            win_id <= '0;
            act_id <= '0;
        end else begin
            state  <= state_d;
            prev   <= src;
            pend_q <= edge_q & ((src & ~prev) | (pend_q & ~clr));
            if (we && addr[3:2] == INT_EN) en <= wd[N_SRC-1:0];
            if (we && addr[3:2] == INT_EDGE) edge_q <= wd[N_SRC-1:0];
            if (state == INT_IDLE && enc_valid) win_id <= enc_id;
            if (claim) act_id <= win_id;
        end
    end
    assign HWInt = state == INT_ASSERT ? 6'(win_oh) : 6'd0;
    assign busy  = state == INT_ACTIVE;
    always_comb
        rd = addr[3:2] == INT_PEND ? 32'(pend) :
             addr[3:2] == INT_EN   ? 32'(en) :
             addr[3:2] == INT_EDGE ? 32'(edge_q) :
             {busy, 28'd0, act_id};
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: table-driven vectors with an expected-result queue for int_ctrl (default build).
module tb_int_ctrl;
    logic        clk = 0, reset = 1, we = 0, cp0_req = 0, busy;
    logic [5:0]  irq_src = 0, HWInt;
    logic [3:0]  addr = 0;
    logic [31:0] wd = 0, rd;
    int total = 0, bad = 0;

    typedef struct {
        logic rst; logic [5:0] irq; logic cp0; logic wr; logic [3:0] a; logic [31:0] d;
        logic [3:0] ra; logic [5:0] hw; logic bz; logic [31:0] rv;
    } vec_t;
    typedef struct { logic [5:0] hw; logic bz; logic [31:0] rv; } exp_t;
    vec_t tbl[$];
    exp_t sbq[$];

    int_ctrl #(.N_SRC(6)) dut (.clk(clk), .reset(reset), .irq_src(irq_src), .we(we), .addr(addr),
        .wd(wd), .rd(rd), .cp0_req(cp0_req), .HWInt(HWInt), .busy(busy));

    always #5 clk = ~clk;

    function automatic vec_t V(logic rst, logic [5:0] irq, logic cp0, logic wr, logic [3:0] a,
                               logic [31:0] d, logic [3:0] ra, logic [5:0] hw, logic bz, logic [31:0] rv);
        V = '{rst, irq, cp0, wr, a, d, ra, hw, bz, rv};
    endfunction

    task automatic chk(input string n, input int k, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", n, k, act, exp);
        end
    endtask

    task automatic step(input int k, input vec_t v);
        exp_t e;
        @(negedge clk);
        reset = v.rst; irq_src = v.irq; cp0_req = v.cp0; we = v.wr; addr = v.a; wd = v.d;
        sbq.push_back('{v.hw, v.bz, v.rv});
        @(posedge clk);
        #1 we = 0; cp0_req = 0; addr = v.ra;
        #1 e = sbq.pop_front();
        chk("hwint", k, 32'(HWInt), 32'(e.hw));
        chk("busy", k, 32'(busy), 32'(e.bz));
        chk("rd", k, rd, e.rv);
    endtask

    initial begin
        // reset state: every register reads zero
        tbl.push_back(V(1, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h0));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h0));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h4, 6'h00, 0, 32'h0));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h8, 6'h00, 0, 32'h0));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'hc, 6'h00, 0, 32'h0));
        // edge source 0: pulse, claim, complete
        tbl.push_back(V(0, 6'h00, 0, 1, 4'h4, 32'h3f, 4'h4, 6'h00, 0, 32'h3f));
        tbl.push_back(V(0, 6'h00, 0, 1, 4'h8, 32'h01, 4'h8, 6'h00, 0, 32'h01));
        tbl.push_back(V(0, 6'h01, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h01));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h01, 0, 32'h01));
        tbl.push_back(V(0, 6'h00, 1, 0, 4'h0, 0, 4'hc, 6'h00, 1, 32'h8000_0000));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 1, 32'h0));
        tbl.push_back(V(0, 6'h00, 0, 1, 4'hc, 32'hdeadbeef, 4'hc, 6'h00, 0, 32'h0));
        // level sources 2 and 4: priority, re-assert after complete
        tbl.push_back(V(0, 6'h00, 0, 1, 4'h4, 32'h14, 4'h4, 6'h00, 0, 32'h14));
        tbl.push_back(V(0, 6'h14, 0, 0, 4'h0, 0, 4'h0, 6'h04, 0, 32'h14));
        tbl.push_back(V(0, 6'h14, 1, 0, 4'h0, 0, 4'hc, 6'h00, 1, 32'h8000_0002));
        tbl.push_back(V(0, 6'h14, 0, 1, 4'hc, 0, 4'h0, 6'h00, 0, 32'h14));
        tbl.push_back(V(0, 6'h14, 0, 0, 4'h0, 0, 4'h0, 6'h04, 0, 32'h14));
        // level drop in ASSERT returns to IDLE with no spurious HWInt
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h0));
        tbl.push_back(V(0, 6'h00, 0, 1, 4'h4, 32'h08, 4'h4, 6'h00, 0, 32'h08));
        tbl.push_back(V(0, 6'h08, 0, 0, 4'h0, 0, 4'h0, 6'h08, 0, 32'h08));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h0));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h0));
        // masked edge source 1, late enable, W1C
        tbl.push_back(V(0, 6'h00, 0, 1, 4'h8, 32'h02, 4'h8, 6'h00, 0, 32'h02));
        tbl.push_back(V(0, 6'h00, 0, 1, 4'h4, 32'h00, 4'h4, 6'h00, 0, 32'h0));
        tbl.push_back(V(0, 6'h02, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h02));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h02));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h02));
        tbl.push_back(V(0, 6'h00, 0, 1, 4'h4, 32'h02, 4'h4, 6'h00, 0, 32'h02));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h02, 0, 32'h02));
        tbl.push_back(V(0, 6'h00, 0, 1, 4'h0, 32'h02, 4'h0, 6'h02, 0, 32'h0));
        tbl.push_back(V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h0));
        // edge set beats same-cycle W1C; claim clears; cp0_req ignored in ACTIVE
        tbl.push_back(V(0, 6'h02, 0, 1, 4'h0, 32'h02, 4'h0, 6'h00, 0, 32'h02));
        tbl.push_back(V(0, 6'h02, 0, 0, 4'h0, 0, 4'h0, 6'h02, 0, 32'h02));
        tbl.push_back(V(0, 6'h02, 1, 0, 4'h0, 0, 4'hc, 6'h00, 1, 32'h8000_0001));
        tbl.push_back(V(0, 6'h02, 0, 0, 4'h0, 0, 4'h0, 6'h00, 1, 32'h0));
        tbl.push_back(V(0, 6'h02, 1, 0, 4'h0, 0, 4'hc, 6'h00, 1, 32'h8000_0001));
        for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

        // hand-written: new edge pending while ACTIVE, then reset drops everything
        step(100, V(0, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 1, 32'h0));
        step(101, V(0, 6'h02, 0, 0, 4'h0, 0, 4'h0, 6'h00, 1, 32'h02));
        step(102, V(1, 6'h00, 0, 0, 4'h0, 0, 4'h0, 6'h00, 0, 32'h0));
        step(103, V(1, 6'h00, 0, 0, 4'h0, 0, 4'h4, 6'h00, 0, 32'h0));
        step(104, V(1, 6'h00, 0, 0, 4'h0, 0, 4'h8, 6'h00, 0, 32'h0));
        step(105, V(1, 6'h00, 0, 0, 4'h0, 0, 4'hc, 6'h00, 0, 32'h0));
        step(106, V(0, 6'h00, 1, 0, 4'h0, 0, 4'hc, 6'h00, 0, 32'h0));

        // hand-written: higher-priority arrival during ASSERT does not preempt
        step(110, V(0, 6'h00, 0, 1, 4'h4, 32'h0c, 4'h4, 6'h00, 0, 32'h0c));
        step(111, V(0, 6'h08, 0, 0, 4'h0, 0, 4'h0, 6'h08, 0, 32'h08));
        step(112, V(0, 6'h0c, 0, 0, 4'h0, 0, 4'h0, 6'h08, 0, 32'h0c));
        step(113, V(0, 6'h0c, 1, 0, 4'h0, 0, 4'hc, 6'h00, 1, 32'h8000_0003));
        step(114, V(0, 6'h0c, 0, 1, 4'hc, 0, 4'h0, 6'h00, 0, 32'h0c));
        step(115, V(0, 6'h0c, 0, 0, 4'h0, 0, 4'h0, 6'h04, 0, 32'h0c));

        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: %0d entries left, want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
